// File: rtl/multiplicador_pkg.sv
// ==== multiplicador_pkg: state encoding, default width and counter sizing for multiplicador -- rev 1.0 ====
`default_nettype none

package multiplicador_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Keeps at least one bit so a WIDTH of 1 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multiplicador_contador.sv
// ==== multiplicador_contador: iteration counter, K flags the last multiplier bit -- rev 1.0 ====
`default_nettype none

module multiplicador_contador
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic K
);

  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] intReg;
  logic [CW-1:0] intReg_d;

  assign K = (intReg == LAST);

  // Wrap to zero on the terminal count so the register never exceeds WIDTH-1.
  always_comb begin
    intReg_d = intReg;
    if (clr) begin
      intReg_d = '0;
    end else if (en) begin
      intReg_d = K ? '0 : intReg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intReg <= '0;
    end else begin
      intReg <= intReg_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multiplicador_ctrl.sv
// ==== multiplicador_ctrl: IDLE/CALC/DONE sequencer for the shift-and-add multiplier -- rev 1.0 ====
`default_nettype none

module multiplicador_ctrl
  import multiplicador_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic st,
  input  logic k,
  output logic idle,
  output logic done,
  output logic load,
  output logic clr,
  output logic en
);

  estado_t estado_atual;
  estado_t estado_prox;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_atual <= IDLE;
    end else begin
      estado_atual <= estado_prox;
    end
  end

  always_comb begin
    estado_prox = estado_atual;
    idle        = 1'b0;
    done        = 1'b0;
    load        = 1'b0;
    clr         = 1'b0;
    en          = 1'b0;
    unique case (estado_atual)
      IDLE: begin
        idle = 1'b1;
        if (st) begin
          load        = 1'b1;
          clr         = 1'b1;
          estado_prox = CALC;
        end
      end
      CALC: begin
        en = 1'b1;
        if (k) begin
          estado_prox = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        estado_prox = IDLE;
      end
      default: begin
        estado_prox = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multiplicador.sv
// ==== multiplicador: sequential unsigned shift-and-add multiplier; MULTIPLICADOR_ASSERT_EN adds sim checks -- rev 1.0 ====
`default_nettype none

module multiplicador
  import multiplicador_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               St,
  input  logic [WIDTH-1:0]   Multiplicando,
  input  logic [WIDTH-1:0]   Multiplicador,
  output logic               Idle,
  output logic               Done,
  output logic [2*WIDTH-1:0] Produto
);

  logic load;
  logic clr;
  logic en;
  logic k;

  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   m_d;
  logic [2*WIDTH:0]   acc_q;
  logic [2*WIDTH:0]   acc_d;
  logic [WIDTH:0]     sum;

  multiplicador_ctrl U1 (
    .clk  (Clk),
    .rst  (Reset),
    .st   (St),
    .k    (k),
    .idle (Idle),
    .done (Done),
    .load (load),
    .clr  (clr),
    .en   (en)
  );

  multiplicador_contador #(
    .WIDTH (WIDTH)
  ) U2 (
    .clk (Clk),
    .rst (Reset),
    .clr (clr),
    .en  (en),
    .K   (k)
  );

  // {carry, A} plus M when Q[0] is set, then the whole accumulator shifts right once.
  always_comb begin
    m_d   = m_q;
    acc_d = acc_q;
    sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, m_q} : '0);
    if (load) begin
      m_d   = Multiplicando;
      acc_d = {1'b0, {WIDTH{1'b0}}, Multiplicador};
    end else if (en) begin
      acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_q   <= '0;
      acc_q <= '0;
    end else begin
      m_q   <= m_d;
      acc_q <= acc_d;
    end
  end

  assign Produto = acc_q[2*WIDTH-1:0];

`ifdef MULTIPLICADOR_ASSERT_EN
  logic [WIDTH-1:0] mult_orig_q;
  logic             done_prev_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mult_orig_q <= '0;
      done_prev_q <= 1'b0;
    end else begin
      if (load) begin
        mult_orig_q <= Multiplicador;
      end
      done_prev_q <= Done;
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      assert (!(Idle && Done));
      assert (int'(U2.intReg) <= int'(WIDTH) - 1);
      assert (!(Done && done_prev_q));
      if (Done) begin
        assert (Produto == ({{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, mult_orig_q}));
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_multiplicador.sv
// ==== tb_multiplicador: directed scoreboard bench for multiplicador -- rev 1.0 ====
`default_nettype none

module tb_multiplicador;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          st  = 1'b0;
  logic [W-1:0]  a   = '0;
  logic [W-1:0]  b   = '0;
  logic          idle;
  logic          done;
  logic [2*W-1:0] prod;

  int tests     = 0;
  int fails     = 0;
  int cyc       = 0;
  int done_cnt  = 0;
  int last_done = 0;
  int gap       = 0;

  logic [2*W-1:0] sb[$];
  int             st_q[$];

  always #5 clk = ~clk;

  multiplicador #(
    .WIDTH (W)
  ) dut (
    .Clk           (clk),
    .Reset         (rst),
    .St            (st),
    .Multiplicando (a),
    .Multiplicador (b),
    .Idle          (idle),
    .Done          (done),
    .Produto       (prod)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every Done pops one expected product and its start cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("idle_done_excl", {31'd0, idle && done}, 32'd0);
      if (done) begin
        done_cnt++;
        gap       = cyc - last_done;
        last_done = cyc;
        check("done_expected", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          check("product", prod, sb.pop_front());
          check("latency", 32'(cyc - st_q.pop_front()), 32'(W));
        end
      end
    end
  end

  task automatic start_op(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic [2*W-1:0] exp);
    @(negedge clk);
    for (int i = 0; i < 40 && !idle; i++) @(negedge clk);
    check("idle_before_start", {31'd0, idle}, 32'd1);
    st = 1'b1;
    a  = ma;
    b  = mb;
    @(posedge clk);
    @(negedge clk);
    sb.push_back(exp);
    st_q.push_back(cyc);
    st = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 60 && done_cnt < target; i++) begin
      @(negedge clk);
      #1;
    end
    check(tag, {31'd0, done_cnt >= target}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #20;
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_prod", prod, 32'd0);
    #30;
    rst = 1'b0;

    start_op(16'd496, 16'd255, 32'd126480);
    wait_done(1, "done_basic");
    @(negedge clk);
    check("idle_return", {31'd0, idle}, 32'd1);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("prod_hold", prod, 32'd126480);

    start_op(16'd0, 16'd12345, 32'd0);
    wait_done(2, "done_zero");
    start_op(16'd1, 16'd65535, 32'd65535);
    wait_done(3, "done_identity");
    start_op(16'd65535, 16'd65535, 32'hFFFE0001);
    wait_done(4, "done_fullscale");

    start_op(16'd1234, 16'd5678, 32'd7006652);
    repeat (3) @(negedge clk);
    st = 1'b1;
    a  = 16'd9;
    b  = 16'd9;
    @(negedge clk);
    st = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
    end
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_one_done", 32'(done_cnt), 32'd5);
    check("busy_prod", prod, 32'd7006652);
    check("busy_idle", {31'd0, idle}, 32'd1);

    start_op(16'd999, 16'd777, 32'd776223);
    repeat (7) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_idle", {31'd0, idle}, 32'd1);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_prod", prod, 32'd0);
    sb.delete();
    st_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start_op(16'd3, 16'd5, 32'd15);
    wait_done(6, "done_after_rst");

    @(negedge clk);
    check("b2b_idle", {31'd0, idle}, 32'd1);
    st = 1'b1;
    a  = 16'd7;
    b  = 16'd9;
    @(posedge clk);
    @(negedge clk);
    sb.push_back(32'd63);
    st_q.push_back(cyc);
    a = 16'd100;
    b = 16'd200;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (idle) break;
    end
    check("b2b_idle2", {31'd0, idle}, 32'd1);
    sb.push_back(32'd20000);
    st_q.push_back(cyc + 1);
    @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    wait_done(8, "done_b2b");
    check("b2b_gap", 32'(gap), 32'd18);
    check("b2b_prod", prod, 32'd20000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
